// File: rtl/uart_rx_buf.sv
// uart_rx_buf: oversampling UART receiver with majority-vote bit decisions,
// optional parity, one or two stop bits, break detection and a receive FIFO.
module uart_rx_buf #(
  parameter int OSR    = 16,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              rx_clk,
  input  logic              rst,
  input  logic              rx,
  input  logic              rx_en,
  input  logic [3:0]        length,
  input  logic              parity_en,
  input  logic              parity_type,
  input  logic              stop,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_parity_err,
  output logic              rx_frame_err,
  output logic              rx_break,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              rx_overrun,
  input  logic              rx_ovr_clr,
  output logic              rx_busy
);

  localparam int CNT_W = $clog2(OSR);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = DATA_W + 3;
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OSR / 2);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(OSR - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP1, STOP2, WAIT_IDLE
  } state_t;

  // Out-of-range lengths fall back to the widest frame the buffer can hold.
  function automatic logic [3:0] eff_len(input logic [3:0] l);
    if (l < 4'd5 || l > 4'(DATA_W)) return 4'(DATA_W);
    return l;
  endfunction

  state_t              state_q, state_d;
  logic [1:0]          sync_q;
  logic [2:0]          samp_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [3:0]          bitn_q, bitn_d;
  logic [3:0]          len_q, len_d;
  logic                par_en_q, par_en_d;
  logic                par_type_q, par_type_d;
  logic                stop_q, stop_d;
  logic                par_bit_q, par_bit_d;
  logic                par_err_q, par_err_d;
  logic                fe_q, fe_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;

  logic                rx_s;
  logic                bit_maj;
  logic                decide;
  logic                push;
  logic                push_brk;
  logic                push_fe;
  logic [ENT_W-1:0]    ent;

  logic [ENT_W-1:0]    mem_q [DEPTH];
  logic [PTR_W-1:0]    wptr_q, rptr_q;
  logic [PTR_W:0]      count_q;
  logic                ovr_q;
  logic                full;
  logic                pop;
  logic                push_ok;
  logic                ovr_set;
  logic [ENT_W-1:0]    head;

  assign rx_s    = sync_q[1];
  assign bit_maj = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);
  assign decide  = (cnt_q == CNT_HALF);

  // Two-flop synchroniser followed by a three-sample history for the vote.
  always_ff @(posedge rx_clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b11;
      samp_q <= 3'b111;
    end else begin
      sync_q <= {sync_q[0], rx};
      samp_q <= {samp_q[1:0], rx_s};
    end
  end

  // Receiver FSM state, sample counter and per-frame working registers.
  always_ff @(posedge rx_clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bitn_q     <= '0;
      len_q      <= 4'(DATA_W);
      par_en_q   <= 1'b0;
      par_type_q <= 1'b0;
      stop_q     <= 1'b0;
      par_bit_q  <= 1'b0;
      par_err_q  <= 1'b0;
      fe_q       <= 1'b0;
      shreg_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bitn_q     <= bitn_d;
      len_q      <= len_d;
      par_en_q   <= par_en_d;
      par_type_q <= par_type_d;
      stop_q     <= stop_d;
      par_bit_q  <= par_bit_d;
      par_err_q  <= par_err_d;
      fe_q       <= fe_d;
      shreg_q    <= shreg_d;
    end
  end

  // Next-state logic: one decision per bit period at mid-bit, push at frame end.
  always_comb begin
    state_d    = state_q;
    cnt_d      = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
    bitn_d     = bitn_q;
    len_d      = len_q;
    par_en_d   = par_en_q;
    par_type_d = par_type_q;
    stop_d     = stop_q;
    par_bit_d  = par_bit_q;
    par_err_d  = par_err_q;
    fe_d       = fe_q;
    shreg_d    = shreg_q;
    push       = 1'b0;
    push_brk   = 1'b0;
    push_fe    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rx_en && !rx_s) state_d = START;
      end
      START: begin
        if (decide) begin
          if (bit_maj) begin
            state_d = IDLE;
          end else begin
            len_d      = eff_len(length);
            par_en_d   = parity_en;
            par_type_d = parity_type;
            stop_d     = stop;
            bitn_d     = '0;
            shreg_d    = '0;
            par_bit_d  = 1'b0;
            par_err_d  = 1'b0;
            fe_d       = 1'b0;
            state_d    = DATA;
          end
        end
      end
      DATA: begin
        if (decide) begin
          for (int i = 0; i < DATA_W; i++) begin
            if (bitn_q == 4'(i)) shreg_d[i] = bit_maj;
          end
          bitn_d = bitn_q + 4'd1;
          if (bitn_q == len_q - 4'd1) state_d = par_en_q ? PARITY : STOP1;
        end
      end
      PARITY: begin
        if (decide) begin
          par_bit_d = bit_maj;
          par_err_d = bit_maj ^ (^shreg_q) ^ par_type_q;
          state_d   = STOP1;
        end
      end
      STOP1: begin
        if (decide) begin
          if (!bit_maj && (shreg_q == '0) && !par_bit_q) begin
            push     = 1'b1;
            push_brk = 1'b1;
            push_fe  = 1'b1;
            state_d  = WAIT_IDLE;
          end else if (stop_q) begin
            fe_d    = !bit_maj;
            state_d = STOP2;
          end else begin
            push    = 1'b1;
            push_fe = !bit_maj;
            state_d = IDLE;
          end
        end
      end
      STOP2: begin
        if (decide) begin
          push    = 1'b1;
          push_fe = fe_q | !bit_maj;
          state_d = IDLE;
        end
      end
      WAIT_IDLE: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ent     = {push_brk, push_fe, par_err_q, shreg_q};
  assign full    = (count_q == (PTR_W + 1)'(DEPTH));
  assign pop     = (count_q != '0) && rx_ready;
  assign push_ok = push && (!full || pop);
  assign ovr_set = push && full && !pop;

  // FIFO pointers, occupancy and the sticky overrun flag.
  always_ff @(posedge rx_clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovr_q   <= 1'b0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop)     rptr_q <= rptr_q + 1'b1;
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (ovr_set)         ovr_q <= 1'b1;
      else if (rx_ovr_clr) ovr_q <= 1'b0;
    end
  end

  // FIFO storage; contents only matter while counted as occupied.
  always_ff @(posedge rx_clk) begin
    if (push_ok) mem_q[wptr_q] <= ent;
  end

  assign head = mem_q[rptr_q];

  // Head entry presented only when valid so an empty FIFO reads as zero.
  always_comb begin
    rx_valid      = (count_q != '0);
    rx_data       = '0;
    rx_parity_err = 1'b0;
    rx_frame_err  = 1'b0;
    rx_break      = 1'b0;
    if (rx_valid) begin
      rx_data       = head[DATA_W-1:0];
      rx_parity_err = head[DATA_W];
      rx_frame_err  = head[DATA_W+1];
      rx_break      = head[DATA_W+2];
    end
  end

  assign rx_overrun = ovr_q;
  assign rx_busy    = (state_q != IDLE);

endmodule

// File: doc/uart_rx_buf.md
# uart_rx_buf

Parametrised oversampling UART receiver with a receive FIFO. It synchronises the serial line, confirms start bits, and samples each bit by majority vote at mid-bit. It supports 5..DATA_W data bits, optional even/odd parity and 1 or 2 stop bits. Each received frame and its per-frame error flags are buffered in a DEPTH-entry FIFO, drained by a valid/ready handshake. It sits between the pad-side rx line and the bus-side UART register block.

## Interface
Parameters:
- OSR, 16, samples per bit period; even, ≥ 8; rx_clk runs at OSR × baud.
- DATA_W, 8, maximum data bits per frame; 5..9.
- DEPTH, 4, FIFO entries; power of two, ≥ 2.

Ports:
- rx_clk  in  1  oversampling clock. Single clock domain.
- rst  in  1  asynchronous, active-high reset.
- rx  in  1  serial line, asynchronous to rx_clk, idle high.
- rx_en  in  1  enables start-bit detection.
- length  in  4  data bits per frame.
- parity_en  in  1  1 = parity bit present.
- parity_type  in  1  0 = even, 1 = odd.
- stop  in  1  0 = one stop bit, 1 = two stop bits.
- rx_data  out  DATA_W  data of the FIFO head entry; LSB = first bit received; unused upper bits 0.
- rx_parity_err  out  1  parity error flag of the head entry.
- rx_frame_err  out  1  framing error flag of the head entry (a stop bit sampled 0).
- rx_break  out  1  break flag of the head entry.
- rx_valid  out  1  FIFO not empty.
- rx_ready  in  1  consumer accepts the head entry.
- rx_overrun  out  1  sticky; set when a frame is dropped because the FIFO is full.
- rx_ovr_clr  in  1  clears rx_overrun.
- rx_busy  out  1  FSM not in IDLE.

## Operation
- **Input conditioning.** rx passes through a 2-flop synchroniser, then a 3-bit sample shift register. The bit decision is the majority of the last three synchronised samples.
- **FSM states.** IDLE, START, DATA, PARITY, STOP1, STOP2, WAIT_IDLE.
  - IDLE: enters START when rx_en = 1 and synchronised rx = 0. The sample counter clears.
  - Counter: counts 0..OSR-1 per bit period and wraps to 0. The bit decision is taken at count == OSR/2.
  - START: if the start decision is 1, the start bit is false and the FSM returns to IDLE with no push. If the decision is 0, length, parity_en, parity_type and stop are latched; later changes are ignored until the next frame.
  - Length rule: a latched length < 5 or > DATA_W is treated as DATA_W.
- **DATA.** Bits are shifted in LSB first. The FSM leaves DATA after the N-th decision, going to PARITY if parity_en = 1, otherwise to STOP1.
- **Parity.** Expected parity bit = XOR of the data bits (even) or its inverse (odd). A mismatch sets parity_err for the frame.
- **Stop bits.** A decision of 0 in STOP1 or STOP2 sets frame_err.
  - With stop = 1, STOP2 follows STOP1; otherwise the frame ends at the STOP1 decision.
  - The frame ends at the final stop decision and the FSM goes directly to IDLE. The remainder of the stop bit is not waited out, so back-to-back frames resynchronise on the next start edge.
- **Break.** Break = all data bits 0, the parity bit 0 (if present), and STOP1 = 0.
  - The entry is pushed with break = 1 and frame_err = 1, and the FSM goes to WAIT_IDLE.
  - WAIT_IDLE returns to IDLE only once synchronised rx = 1.
- **FIFO.**
  - Entry = {break, frame_err, parity_err, data}.
  - Push happens on the cycle after the final stop decision. Pop happens when rx_valid && rx_ready.
  - Push while full: the frame is dropped, rx_overrun is set, and FIFO contents are unchanged.
  - Simultaneous push and pop while full: the pop frees a slot, the push is accepted, and rx_overrun is unchanged.
  - Pointers wrap modulo DEPTH.
  - When empty, rx_data and all head flags read 0.
- **Overrun clear.** rx_ovr_clr clears rx_overrun. If rx_ovr_clr and a new overrun occur in the same cycle, the set wins.
- **rx_en.** Deasserting rx_en mid-frame does not abort the frame; it only blocks new start detection.
- **Reset.** Asynchronous reset has effect mid-frame or mid-handshake.
  - FSM goes to IDLE, the counter clears, and the FIFO empties.
  - rx_valid, rx_busy, rx_overrun, the flags and rx_data all go to 0.
  - Synchroniser flops reset to 1.

## Timing
- E = cycle START is entered = pin falling edge + 3 cycles (2 synchroniser + 1 detect).
- Start decision at E+OSR/2.
- Decision for bit k (k = 1..N data, then parity, then stops) at E+OSR/2+k·OSR.
- Frame has B = N + P + S bits after start. Final decision at E+OSR/2+B·OSR; rx_valid is high one cycle later.
- Example, 8N1 at OSR = 16: rx_valid at E+153.
- rx_busy is high from E through the final decision cycle.
- rx_data and flags are stable while rx_valid && !rx_ready.
- Throughput: one push and one pop per cycle, concurrently.

## Test plan
- 8N1, OSR = 16, frame 0xA5, rx_ready = 1 → rx_valid pulses for 1 cycle at E+153 with rx_data = 0xA5 and all flags 0.
- 7E2 frames 0x35 then 0x36 with parity bits 0 and 1 → first entry correct; second has parity_err = 1, data = 0x36.
- Low glitch of 4 samples on an idle line → FSM returns to IDLE, no push, rx_valid stays 0.
- 6N1 frame 0x2A with the stop bit driven 0 → frame_err = 1, break = 0, data = 0x2A.
- Line held low for 20 bit periods, 8N1 → one entry with break = 1, frame_err = 1, data = 0; no further pushes until rx returns high.
- DEPTH = 4, rx_ready = 0, five frames 0x01..0x05 → FIFO holds 0x01..0x04 and rx_overrun = 1. Popping yields 0x01..0x04 in order. rx_ovr_clr clears rx_overrun. Reset asserted mid-frame gives rx_valid = 0 and rx_busy = 0 at once.
